// File: rtl/mem_access_unit.sv
// Memory-stage access controller for the 5-stage RV32I pipeline.
// Turns the M-stage load/store into a valid/ready request on the data-memory
// port. It stalls the pipeline until the access completes, then aligns and
// extends the load data into read_data_m.
module mem_access_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_m,
  input  logic        mem_write_m,
  input  logic [2:0]  funct3_m,
  input  logic [31:0] alu_result_m,
  input  logic [31:0] write_data_m,
  output logic [31:0] read_data_m,
  output logic        stall_m,
  output logic        fault_m,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic        dmem_req_we,
  output logic [31:0] dmem_req_addr,
  output logic [31:0] dmem_req_wdata,
  output logic [3:0]  dmem_req_wstrb,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rsp_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t           state_q, state_d;
  logic             we_q;
  logic [31:0]      addr_q;
  logic [2:0]       f3_q;
  logic [31:0]      wdata_q;
  logic [3:0]       wstrb_q;
  logic [CNT_W-1:0] cnt_q;
  logic             timeout_q;

  logic        access, f3_ok, misalign, bad, start;
  logic        cnt_last;
  logic [31:0] wdata_new;
  logic [3:0]  wstrb_new;

  // Pick the byte/half addressed by a[1:0] and sign- or zero-extend it.
  function automatic logic [31:0] extend(input logic [2:0] f3,
                                         input logic [1:0] a,
                                         input logic [31:0] w);
    logic [31:0] sh;
    sh = w >> {a, 3'b000};
    case (f3)
      3'b000:  extend = {{24{sh[7]}}, sh[7:0]};
      3'b100:  extend = {24'h0, sh[7:0]};
      3'b001:  extend = {{16{sh[15]}}, sh[15:0]};
      3'b101:  extend = {16'h0, sh[15:0]};
      default: extend = w;
    endcase
  endfunction

  // Decode legality of the M-stage access and build the store lanes.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    access    = mem_read_m | mem_write_m;
    f3_ok     = 1'b0;
    wstrb_new = 4'b0000;
    wdata_new = write_data_m;
    case (funct3_m)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = mem_read_m;  // unsigned widths are load-only
      default:                f3_ok = 1'b0;
    endcase
    misalign = ((funct3_m[1:0] == 2'b01) & alu_result_m[0]) |
               ((funct3_m[1:0] == 2'b10) & (alu_result_m[1:0] != 2'b00));
    bad      = ~f3_ok | (mem_read_m & mem_write_m) | misalign;
    start    = (mem_read_m ^ mem_write_m) & ~bad;
    if (mem_write_m) begin
      case (funct3_m[1:0])
        2'b00: begin
          wstrb_new = 4'b0001 << alu_result_m[1:0];
          wdata_new = {4{write_data_m[7:0]}};
        end
        2'b01: begin
          wstrb_new = 4'b0011 << alu_result_m[1:0];
          wdata_new = {2{write_data_m[15:0]}};
        end
        default: wstrb_new = 4'b1111;
      endcase
    end
  end

  assign cnt_last = (cnt_q == CNT_W'(TIMEOUT - 1));

  // Next-state logic and handshake/stall outputs.
  always_comb begin
    state_d        = state_q;
    stall_m        = 1'b0;
    fault_m        = 1'b0;
    dmem_req_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          stall_m = 1'b1;
          state_d = REQ;
        end else if (access) begin
          fault_m = 1'b1;
        end
      end
      REQ: begin
        stall_m        = 1'b1;
        dmem_req_valid = 1'b1;
        if (dmem_req_ready) state_d = we_q ? DONE : WAIT;
      end
      WAIT: begin
        stall_m = 1'b1;
        if (dmem_rsp_valid || cnt_last) state_d = DONE;
      end
      DONE: begin
        fault_m = timeout_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign dmem_req_we    = we_q;
  assign dmem_req_addr  = {addr_q[31:2], 2'b00};
  assign dmem_req_wdata = wdata_q;
  assign dmem_req_wstrb = wstrb_q;

  // State register plus latched request, wait counter, timeout flag and load data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      f3_q        <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
      read_data_m <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            we_q    <= mem_write_m;
            addr_q  <= alu_result_m;
            f3_q    <= funct3_m;
            wdata_q <= wdata_new;
            wstrb_q <= wstrb_new;
          end
        end
        REQ: begin
          if (dmem_req_ready) cnt_q <= '0;
        end
        WAIT: begin
          if (dmem_rsp_valid) begin
            read_data_m <= extend(f3_q, addr_q[1:0], dmem_rsp_rdata);
          end else if (cnt_last) begin
            read_data_m <= '0;
            timeout_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: timeout_q <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit: loads, stores, faults, timeout, reset.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_m, mem_write_m;
  logic [2:0]  funct3_m;
  logic [31:0] alu_result_m, write_data_m;
  logic [31:0] read_data_m;
  logic        stall_m, fault_m;
  logic        dmem_req_valid, dmem_req_ready, dmem_req_we;
  logic [31:0] dmem_req_addr, dmem_req_wdata;
  logic [3:0]  dmem_req_wstrb;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rsp_rdata;

  int n_vec = 0;
  int n_err = 0;

  mem_access_unit #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .mem_read_m(mem_read_m), .mem_write_m(mem_write_m),
    .funct3_m(funct3_m), .alu_result_m(alu_result_m), .write_data_m(write_data_m),
    .read_data_m(read_data_m), .stall_m(stall_m), .fault_m(fault_m),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_req_we(dmem_req_we), .dmem_req_addr(dmem_req_addr),
    .dmem_req_wdata(dmem_req_wdata), .dmem_req_wstrb(dmem_req_wstrb),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_rdata(dmem_rsp_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    mem_read_m     = 1'b0;
    mem_write_m    = 1'b0;
    funct3_m       = 3'b000;
    alu_result_m   = '0;
    write_data_m   = '0;
    dmem_rsp_valid = 1'b0;
  endtask

  // Load with ready and response both immediate: IDLE, REQ, WAIT, DONE.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] rdata, input logic [31:0] exp);
    @(negedge clk);
    mem_read_m = 1'b1; mem_write_m = 1'b0; funct3_m = f3; alu_result_m = a;
    dmem_req_ready = 1'b1; dmem_rsp_valid = 1'b0;
    #1 check({tag, "_idle_stall"}, 32'(stall_m), 32'd1);
    check({tag, "_idle_valid"}, 32'(dmem_req_valid), 32'd0);
    @(negedge clk); #1;
    check({tag, "_req_valid"}, 32'(dmem_req_valid), 32'd1);
    check({tag, "_req_addr"}, dmem_req_addr, {a[31:2], 2'b00});
    check({tag, "_req_wstrb"}, 32'(dmem_req_wstrb), 32'd0);
    check({tag, "_req_we"}, 32'(dmem_req_we), 32'd0);
    @(negedge clk);
    #1 check({tag, "_wait_stall"}, 32'(stall_m), 32'd1);
    dmem_rsp_valid = 1'b1; dmem_rsp_rdata = rdata;
    @(negedge clk);
    dmem_rsp_valid = 1'b0; mem_read_m = 1'b0;
    #1 check({tag, "_done_stall"}, 32'(stall_m), 32'd0);
    check({tag, "_done_fault"}, 32'(fault_m), 32'd0);
    check({tag, "_done_data"}, read_data_m, exp);
  endtask

  // Illegal access: fault for one cycle, no request, no stall.
  task automatic bad_access(input string tag, input logic rd, input logic wr,
                            input logic [2:0] f3, input logic [31:0] a);
    @(negedge clk);
    mem_read_m = rd; mem_write_m = wr; funct3_m = f3; alu_result_m = a;
    write_data_m = 32'hFFFF_FFFF;
    #1 check({tag, "_fault"}, 32'(fault_m), 32'd1);
    check({tag, "_stall"}, 32'(stall_m), 32'd0);
    check({tag, "_valid"}, 32'(dmem_req_valid), 32'd0);
    @(negedge clk);
    #1 check({tag, "_valid_next"}, 32'(dmem_req_valid), 32'd0);
    idle_inputs();
    #1 check({tag, "_fault_clr"}, 32'(fault_m), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    dmem_req_ready = 1'b0;
    dmem_rsp_rdata = '0;
    idle_inputs();
    repeat (2) @(negedge clk);
    #1 check("rst_data", read_data_m, 32'd0);
    check("rst_valid", 32'(dmem_req_valid), 32'd0);
    check("rst_stall", 32'(stall_m), 32'd0);
    check("rst_fault", 32'(fault_m), 32'd0);
    rst = 1'b0;

    do_load("lw",  3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    do_load("lb",  3'b000, 32'h0000_0203, 32'h8011_2233, 32'hFFFF_FF80);
    do_load("lbu", 3'b100, 32'h0000_0203, 32'h8011_2233, 32'h0000_0080);

    // SB with ready held low 3 cycles: request fields stay stable.
    @(negedge clk);
    mem_write_m = 1'b1; funct3_m = 3'b000; alu_result_m = 32'h41;
    write_data_m = 32'hA5; dmem_req_ready = 1'b0;
    #1 check("sb_idle_stall", 32'(stall_m), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 3) dmem_req_ready = 1'b1;
      #1 check($sformatf("sb_req%0d_valid", i), 32'(dmem_req_valid), 32'd1);
      check($sformatf("sb_req%0d_we", i), 32'(dmem_req_we), 32'd1);
      check($sformatf("sb_req%0d_addr", i), dmem_req_addr, 32'h40);
      check($sformatf("sb_req%0d_wstrb", i), 32'(dmem_req_wstrb), 32'b0010);
      check($sformatf("sb_req%0d_wdata", i), dmem_req_wdata, 32'hA5A5_A5A5);
    end
    @(negedge clk);
    idle_inputs();
    #1 check("sb_done_stall", 32'(stall_m), 32'd0);
    check("sb_done_valid", 32'(dmem_req_valid), 32'd0);
    check("sb_done_data", read_data_m, 32'h0000_0080);

    bad_access("lw_misal", 1'b1, 1'b0, 3'b010, 32'h102);
    bad_access("sh_misal", 1'b0, 1'b1, 3'b001, 32'h11);
    bad_access("rd_and_wr", 1'b1, 1'b1, 3'b010, 32'h100);
    bad_access("sbu_store", 1'b0, 1'b1, 3'b100, 32'h100);

    // Non-memory instruction: no stall, no fault, data held.
    @(negedge clk);
    funct3_m = 3'b111; alu_result_m = 32'h3;
    #1 check("nop_stall", 32'(stall_m), 32'd0);
    check("nop_fault", 32'(fault_m), 32'd0);
    check("nop_data", read_data_m, 32'h0000_0080);
    idle_inputs();

    // Timeout: no response ever, 16 WAIT cycles then a faulting DONE.
    @(negedge clk);
    mem_read_m = 1'b1; funct3_m = 3'b010; alu_result_m = 32'h300; dmem_req_ready = 1'b1;
    @(negedge clk);
    #1 check("to_req_valid", 32'(dmem_req_valid), 32'd1);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      #1 check($sformatf("to_wait%0d_stall", i), 32'(stall_m), 32'd1);
    end
    @(negedge clk);
    mem_read_m = 1'b0;
    #1 check("to_done_fault", 32'(fault_m), 32'd1);
    check("to_done_stall", 32'(stall_m), 32'd0);
    check("to_done_data", read_data_m, 32'd0);
    @(negedge clk);
    #1 check("to_idle_fault", 32'(fault_m), 32'd0);

    do_load("lhu", 3'b101, 32'h0000_0202, 32'h8011_2233, 32'h0000_8011);

    // Reset while in WAIT, then a late response that must be ignored.
    @(negedge clk);
    mem_read_m = 1'b1; funct3_m = 3'b010; alu_result_m = 32'h400; dmem_req_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1 check("rw_wait_stall", 32'(stall_m), 32'd1);
    rst = 1'b1; mem_read_m = 1'b0;
    #1 check("rw_stall", 32'(stall_m), 32'd0);
    check("rw_valid", 32'(dmem_req_valid), 32'd0);
    check("rw_data", read_data_m, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dmem_rsp_valid = 1'b1; dmem_rsp_rdata = 32'h1234_5678;
    repeat (2) @(negedge clk);
    #1 check("late_rsp_data", read_data_m, 32'd0);
    check("late_rsp_stall", 32'(stall_m), 32'd0);
    check("late_rsp_fault", 32'(fault_m), 32'd0);
    dmem_rsp_valid = 1'b0;

    // Reset while the request is pending drops req_valid at once.
    @(negedge clk);
    mem_read_m = 1'b1; funct3_m = 3'b010; alu_result_m = 32'h500; dmem_req_ready = 1'b0;
    @(negedge clk);
    #1 check("rr_valid_before", 32'(dmem_req_valid), 32'd1);
    rst = 1'b1; mem_read_m = 1'b0;
    #1 check("rr_valid", 32'(dmem_req_valid), 32'd0);
    check("rr_stall", 32'(stall_m), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage access controller for the 5-stage RV32I pipeline. It sits between the EX/MEM and MEM/WB pipeline registers.
- Converts the M-stage load/store into a valid/ready request on the data-memory port and stalls the pipeline until the access completes.
- Aligns and sign/zero-extends load data into read_data_m, which the MEM/WB register captures as ReadDataM.

Parameters:
- TIMEOUT, 16: maximum cycles spent in WAIT before the access is aborted with a fault.
- CNT_W, 5: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- mem_read_m  in  1  M-stage instruction is a load.
- mem_write_m  in  1  M-stage instruction is a store.
- funct3_m  in  3  load/store width and sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
- alu_result_m  in  32  byte address.
- write_data_m  in  32  store data, right-aligned.
- read_data_m  out  32  extended load data, registered.
- stall_m  out  1  freezes PC, IF/ID, ID/EX and EX/MEM; bubbles MEM/WB.
- fault_m  out  1  misaligned, illegal or timed-out access.
- dmem_req_valid  out  1  request valid.
- dmem_req_ready  in  1  memory accepts request.
- dmem_req_we  out  1  1 = write.
- dmem_req_addr  out  32  word address: {addr[31:2], 2'b00}.
- dmem_req_wdata  out  32  lane-replicated store data.
- dmem_req_wstrb  out  4  byte enables.
- dmem_rsp_valid  in  1  read data valid.
- dmem_rsp_rdata  in  32  read word.

Behaviour:
- FSM states: IDLE, REQ, WAIT, DONE. Reset state is IDLE.
- Reset: read_data_m=0, state=IDLE, counter=0, latched request fields=0. dmem_req_valid drops immediately on rst, including mid-access; any later response is ignored.
- start = (mem_read_m ^ mem_write_m) & ~bad.
- bad = (funct3 not in {000,001,010,100,101}) | (mem_read_m & mem_write_m) | (H/HU & a[0]) | (W & a[1:0]!=0). Stores accept only 000/001/010.
- IDLE:
  - On start: latch we, addr, funct3, wdata and wstrb; next state REQ.
  - On a bad access: fault_m=1 for that cycle, no request, no stall, state stays IDLE, store suppressed, read_data_m unchanged.
- REQ: dmem_req_valid=1 with stable latched fields until dmem_req_ready. On the handshake edge: write → DONE, read → WAIT with counter cleared.
- WAIT:
  - rsp_valid is never sampled in the handshake cycle.
  - On dmem_rsp_valid: read_data_m <= extend(rsp_rdata), next state DONE.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 without a response: read_data_m <= 0, timeout flag set, next state DONE.
- DONE: stall_m=0, fault_m=timeout flag (cleared on exit), next state IDLE. The pipeline advances on this edge, so the instruction is not re-issued.
- stall_m = (IDLE & start) | REQ | WAIT. This is combinational in IDLE and Moore elsewhere.
- Write lanes:
  - SB: wstrb=4'b0001<<a[1:0], wdata={4{wd[7:0]}}.
  - SH: wstrb=4'b0011<<a[1:0], wdata={2{wd[15:0]}}.
  - SW: wstrb=4'b1111, wdata=wd.
- Load extension: select the byte/half using latched a[1:0]. LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
- Latency with ready and response both immediate: load occupies M for 4 cycles (IDLE, REQ, WAIT, DONE). Store occupies M for 3 cycles (IDLE, REQ, DONE).
- Non-memory instructions pass through with no stall; read_data_m holds its last value.

Test Plan:
- LW addr 0x100, ready=1, rsp next cycle rdata 0xDEADBEEF → stall high 3 cycles; req_addr 0x100, wstrb 0, we 0; read_data_m=0xDEADBEEF in DONE; fault 0.
- LB addr 0x203 with rdata 0x80112233 → 0xFFFFFF80. LBU same → 0x00000080. LHU addr 0x202 → 0x00008011.
- SB addr 0x41, wd 0x000000A5, ready low 3 cycles → req_valid held 3+1 cycles with stable fields; wstrb=0010, wdata=0xA5A5A5A5; stall drops in DONE.
- LW addr 0x102 → fault_m pulses 1 cycle; no req_valid; no stall. SH addr 0x11 → same behaviour, no write issued.
- LW with rsp_valid never asserted, TIMEOUT=16 → DONE after 16 WAIT cycles; read_data_m=0; fault_m=1 for 1 cycle; FSM returns to IDLE.
- rst asserted during WAIT → req_valid/stall_m low immediately, read_data_m=0. A late rsp_valid after rst release has no effect.
